// File: rtl/fifo_ctrl_pkg.sv
// Shared FIFO constants (depth, pointer width, watermarks, data width) and the
// accepted-operation encoding used by the controller.
package fifo_ctrl_pkg;

    localparam int ADDR_W_DEF    = 3;
    localparam int DEPTH_DEF     = 2 ** ADDR_W_DEF;
    localparam int AF_THRESH_DEF = 6;
    localparam int AE_THRESH_DEF = 2;
    // Width of the memory word, shared with the memory and the probador.
    localparam int DATA_W        = 10;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Handshake/status bundle between producer/consumer logic (master) and the
// FIFO controller (slave).
interface fifo_ctrl_if #(
    parameter int ADDR_W = fifo_ctrl_pkg::ADDR_W_DEF
);
    logic              push;
    logic              pop;
    logic              wr_enb;
    logic              rd_enb;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   fifo_cnt;
    logic              overflow;
    logic              underflow;
    logic              data_valid;

    modport master (
        output push, pop,
        input  wr_enb, rd_enb, wr_ptr, rd_ptr, full, empty, almost_full,
               almost_empty, fifo_cnt, overflow, underflow, data_valid
    );

    modport slave (
        input  push, pop,
        output wr_enb, rd_enb, wr_ptr, rd_ptr, full, empty, almost_full,
               almost_empty, fifo_cnt, overflow, underflow, data_valid
    );
endinterface

// File: rtl/ptr_counter.sv
// ADDR_W-bit wrapping address counter with synchronous reset and increment enable.
module ptr_counter #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy, flags, sticky errors, read-valid.
// Define FIFO_WATERMARK_EN to derive almost_full/almost_empty from the thresholds.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int AF_THRESH = AF_THRESH_DEF,
    parameter int AE_THRESH = AE_THRESH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    fifo_ctrl_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (AF_THRESH < 0 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_thresh_chk
        $error("fifo_ctrl: watermark thresholds out of range");
    end

    logic [ADDR_W:0] cnt;
    logic            wr_acc;
    logic            rd_acc;
    logic            overflow_r;
    logic            underflow_r;
    logic            vld_p1;
    op_e             op;

    // Acceptance uses the registered count, so a full FIFO never reads and
    // writes the same slot on one edge, and an empty FIFO has no fall-through.
    assign wr_acc = bus.push & ~bus.full  & ~rst;
    assign rd_acc = bus.pop  & ~bus.empty & ~rst;

    always_comb begin
        op = OP_IDLE;
        case ({wr_acc, rd_acc})
            2'b10:   op = OP_WR;
            2'b01:   op = OP_RD;
            2'b11:   op = OP_BOTH;
            default: op = OP_IDLE;
        endcase
    end

    ptr_counter #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_acc),
        .ptr (bus.wr_ptr)
    );

    ptr_counter #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_acc),
        .ptr (bus.rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            case (op)
                OP_WR:   cnt <= cnt + 1'b1;
                OP_RD:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            overflow_r  <= overflow_r  | (bus.push & bus.full);
            underflow_r <= underflow_r | (bus.pop  & bus.empty);
            vld_p1      <= rd_acc;
        end
    end

    assign bus.wr_enb     = wr_acc;
    assign bus.rd_enb     = rd_acc;
    assign bus.fifo_cnt   = cnt;
    assign bus.full       = (cnt == (ADDR_W+1)'(DEPTH));
    assign bus.empty      = (cnt == '0);
    assign bus.overflow   = overflow_r;
    assign bus.underflow  = underflow_r;
    assign bus.data_valid = vld_p1;

`ifdef FIFO_WATERMARK_EN
    assign bus.almost_full  = (cnt >= (ADDR_W+1)'(AF_THRESH));
    assign bus.almost_empty = (cnt <= (ADDR_W+1)'(AE_THRESH));
`else
    assign bus.almost_full  = bus.full;
    assign bus.almost_empty = bus.empty;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a behavioural 8x10 memory and a data scoreboard.
module tb_fifo_ctrl;
    import fifo_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_ctrl_if #(.ADDR_W(3)) bus ();

    fifo_ctrl #(.ADDR_W(3), .AF_THRESH(6), .AE_THRESH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory end of the FIFO, modelled in the bench.
    logic [DATA_W-1:0] mem [8];
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    always @(posedge clk) begin
        if (bus.wr_enb) mem[bus.wr_ptr] <= din;
        if (bus.rd_enb) dout <= mem[bus.rd_ptr];
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int          m_cnt = 0;
    logic [2:0]  m_wp  = '0;
    logic [2:0]  m_rp  = '0;
    bit          m_ovf = 1'b0;
    bit          m_und = 1'b0;
    bit          m_dv  = 1'b0;
    int          m_dexp = 0;
    int          next_data = 25;
    int          sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit p, input bit q, input bit r);
        bit exp_wr, exp_rd;
        @(negedge clk);
        rst      = r;
        bus.push = p;
        bus.pop  = q;
        din      = DATA_W'(next_data);
        #1;
        exp_wr = p && (m_cnt != 8) && !r;
        exp_rd = q && (m_cnt != 0) && !r;
        chk("wr_enb", int'(bus.wr_enb), int'(exp_wr));
        chk("rd_enb", int'(bus.rd_enb), int'(exp_rd));
        @(posedge clk);
        if (r) begin
            m_cnt = 0; m_wp = '0; m_rp = '0; m_ovf = 0; m_und = 0; m_dv = 0;
            sb.delete();
        end else begin
            if (p && m_cnt == 8) m_ovf = 1;
            if (q && m_cnt == 0) m_und = 1;
            if (exp_wr) begin
                sb.push_back(next_data);
                next_data += 20;
                m_wp++;
                m_cnt++;
            end
            m_dv = exp_rd;
            if (exp_rd) begin
                if (sb.size() > 0) m_dexp = sb.pop_front();
                m_rp++;
                m_cnt--;
            end
        end
        #1;
        chk("fifo_cnt", int'(bus.fifo_cnt), m_cnt);
        chk("wr_ptr", int'(bus.wr_ptr), int'(m_wp));
        chk("rd_ptr", int'(bus.rd_ptr), int'(m_rp));
        chk("full", int'(bus.full), int'(m_cnt == 8));
        chk("empty", int'(bus.empty), int'(m_cnt == 0));
`ifdef FIFO_WATERMARK_EN
        chk("almost_full", int'(bus.almost_full), int'(m_cnt >= 6));
        chk("almost_empty", int'(bus.almost_empty), int'(m_cnt <= 2));
`else
        chk("almost_full", int'(bus.almost_full), int'(m_cnt == 8));
        chk("almost_empty", int'(bus.almost_empty), int'(m_cnt == 0));
`endif
        chk("overflow", int'(bus.overflow), int'(m_ovf));
        chk("underflow", int'(bus.underflow), int'(m_und));
        chk("data_valid", int'(bus.data_valid), int'(m_dv));
        if (m_dv) chk("data_out", int'(dout), m_dexp);
    endtask

    typedef struct {
        bit push;
        bit pop;
        int cnt;
        bit ovf;
        bit und;
    } vec_t;

    vec_t tbl [22];

    initial begin
        // Fill, overflow, full push+pop, drain with wrap, underflow, empty push+pop.
        for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 1'b0, i + 1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 7, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) tbl[11 + i] = '{1'b0, 1'b1, 7 - i, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 0, 1'b1, 1'b1};
        tbl[20] = '{1'b1, 1'b1, 1, 1'b1, 1'b1};
        tbl[21] = '{1'b0, 1'b1, 0, 1'b1, 1'b1};

        bus.push = 1'b0;
        bus.pop  = 1'b0;
        din      = '0;

        // Reset held two cycles, then one idle cycle at reset values.
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].push, tbl[i].pop, 0);
            chk("tbl_cnt", int'(bus.fifo_cnt), tbl[i].cnt);
            chk("tbl_ovf", int'(bus.overflow), int'(tbl[i].ovf));
            chk("tbl_und", int'(bus.underflow), int'(tbl[i].und));
        end

        // Steady push+pop at count 4; both pointers wrap past 7.
        step(0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 0);
        chk("simul_cnt", int'(bus.fifo_cnt), 4);
        chk("simul_wp", int'(bus.wr_ptr), 6);
        chk("simul_rp", int'(bus.rd_ptr), 2);
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        chk("simul_empty", int'(bus.empty), 1);

        // Reset mid-operation at count 5 with overflow set, push held high.
        for (int i = 0; i < 9; i++) step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        chk("pre_rst_cnt", int'(bus.fifo_cnt), 5);
        chk("pre_rst_ovf", int'(bus.overflow), 1);
        step(1, 0, 1);
        chk("rst_cnt", int'(bus.fifo_cnt), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        chk("rst_dv", int'(bus.data_valid), 0);
        step(0, 0, 0);
        chk("post_rst_wp", int'(bus.wr_ptr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
